// File: rtl/mem_copy_master.sv
// rtl/mem_copy_master.sv - Bus master that copies a byte range inside a single-port memory
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start               copy command, accepted only when no copy is running
//   src_addr, dst_addr  first source / destination address, captured on start
//   len                 byte count 0..2^ADDR_W, larger values clamp to 2^ADDR_W
//   busy                high while a copy is in progress
//   done                one-cycle pulse when a copy ends, normally or by timeout
//   err                 set by a timeout abort, cleared by the next accepted start
//   count               bytes fully written in the current or last copy
//   read, write, addr   memory request; held until ack is sampled
//   data_i              write data towards the memory
//   data_o              read data from the memory, valid with ack during a read
//   ack                 one-cycle memory completion pulse
module mem_copy_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] data_o,
    input  logic              ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W:0]   len_r;
    logic [TW-1:0]     tcnt;
    logic              timeout_hit;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W-1:0] src_next;

    // The request has already been high TIMEOUT-1 cycles without ack, so
    // this edge completes exactly TIMEOUT cycles of waiting.
    assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
    assign count_next  = count + (ADDR_W + 1)'(1);
    assign src_next    = src_r + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            count  <= '0;
            read   <= 1'b0;
            write  <= 1'b0;
            addr   <= '0;
            data_i <= '0;
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            tcnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_r <= src_addr;
                        dst_r <= dst_addr;
                        len_r <= (len > MAX_LEN) ? MAX_LEN : len;
                        err   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        tcnt  <= '0;
                        if (len == '0) begin
                            // Empty copy still shows one busy cycle before done.
                            state <= S_FIN;
                        end else begin
                            state <= S_RD;
                            read  <= 1'b1;
                            addr  <= src_addr;
                        end
                    end
                end
                S_RD: begin
                    if (ack) begin
                        read   <= 1'b0;
                        write  <= 1'b1;
                        addr   <= dst_r;
                        data_i <= data_o;
                        tcnt   <= '0;
                        state  <= S_WR;
                    end else if (timeout_hit) begin
                        read  <= 1'b0;
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WR: begin
                    if (ack) begin
                        write <= 1'b0;
                        count <= count_next;
                        src_r <= src_next;
                        dst_r <= dst_r + ADDR_W'(1);
                        tcnt  <= '0;
                        if (count_next == len_r) begin
                            // Finish straight away so done lands in the cycle
                            // right after the last write ack.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            read  <= 1'b1;
                            addr  <= src_next;
                            state <= S_RD;
                        end
                    end else if (timeout_hit) begin
                        write <= 1'b0;
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
